alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                  |
// | Brief    : Round-robin arbiter that shares one combinational ALU        |
// |            between two requesters, one transaction in flight.           |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_grant;
  logic             r_last;
  logic             r_illegal;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;

  logic             w_grant;
  logic             w_take;
  logic             w_resp_done;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  logic [3:0]       w_op_in;

  function automatic logic f_op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: f_op_legal = 1'b1;
      default:                                              f_op_legal = 1'b0;
    endcase
  endfunction

  // On a tie the requester that was not granted last time wins.
  assign w_grant = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_take  = (r_state == ST_IDLE) && (req0_valid || req1_valid);
  assign w_a_in  = w_grant ? req1_a  : req0_a;
  assign w_b_in  = w_grant ? req1_b  : req0_b;
  assign w_op_in = w_grant ? req1_op : req0_op;

  // Readiness is masked by rst_n so it drops the moment reset asserts.
  assign req0_ready = rst_n && w_take && !w_grant;
  assign req1_ready = rst_n && w_take &&  w_grant;

  assign resp0_valid = (r_state == ST_RESP) && !r_grant;
  assign resp1_valid = (r_state == ST_RESP) &&  r_grant;
  assign w_resp_done = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_control = r_illegal ? 4'b0000 : r_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_take)      w_state_nxt = ST_EXEC;
      ST_EXEC:                  w_state_nxt = ST_RESP;
      ST_RESP: if (w_resp_done) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_illegal   <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 4'b0000;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (w_take) begin
        r_grant   <= w_grant;
        r_last    <= w_grant;
        r_a       <= w_a_in;
        r_b       <= w_b_in;
        r_op      <= w_op_in;
        r_illegal <= !f_op_legal(w_op_in);
      end
      if (r_state == ST_EXEC) begin
        resp_result <= r_illegal ? '0 : alu_result;
        resp_zero   <= r_illegal ? 1'b0 : alu_zero;
        resp_err    <= r_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Randomized bench for alu_arbiter: a behavioural ALU drives the DUT's ALU
// port, and an arbitration/result model predicts every response.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam logic [3:0] LEGAL_OPS [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero, resp_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_control;
  logic             alu_zero;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b0110: alu_fn = a - b;
      4'b0111: alu_fn = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      4'b1100: alu_fn = ~(a | b);
      default: alu_fn = '0;
    endcase
  endfunction

  function automatic bit op_legal(input logic [3:0] op);
    op_legal = 1'b0;
    foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) op_legal = 1'b1;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_control, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_req_ready"},  {req0_ready, req1_ready}, 0);
    check({pfx, "_resp_valid"}, {resp0_valid, resp1_valid}, 0);
    check({pfx, "_result"},     resp_result, 0);
    check({pfx, "_zero_err"},   {resp_zero, resp_err}, 0);
    check({pfx, "_alu_ab"},     {alu_a, alu_b}, 0);
    check({pfx, "_alu_ctl"},    alu_control, 0);
  endtask

  // Enters and leaves at posedge+1 of an IDLE cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    #2;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 1'b1;
    @(posedge clk); #1;
  endtask

  // Enters and leaves at posedge+1 of an IDLE cycle.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [3:0] op0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                         input logic [3:0] op1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                         input int hold);
    bit               g, exp_err, exp_zero;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b, exp_res;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    resp0_ready = 0; resp1_ready = 0;
    g = (v0 && v1) ? ~model_last : v1;
    model_last = g;
    op = g ? op1 : op0;
    a  = g ? a1  : a0;
    b  = g ? b1  : b0;
    exp_err  = !op_legal(op);
    exp_res  = exp_err ? '0 : alu_fn(op, a, b);
    exp_zero = !exp_err && (exp_res == '0);
    #2;
    check("idle_resp_valid", {resp0_valid, resp1_valid}, 0);
    check("grant_ready",     {req0_ready, req1_ready}, g ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    // After acceptance the granted requester scrambles its inputs.
    if (g) begin
      req1_valid = 0; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
      resp0_ready = 1'($urandom);
    end else begin
      req0_valid = 0; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
      resp1_ready = 1'($urandom);
    end
    #2;
    check("exec_alu_ab",     {alu_a, alu_b}, {a, b});
    check("exec_alu_ctl",    alu_control, exp_err ? 4'b0000 : op);
    check("exec_resp_valid", {resp0_valid, resp1_valid}, 0);
    check("exec_req_ready",  {req0_ready, req1_ready}, 0);
    for (int k = 0; k <= hold; k++) begin
      @(posedge clk); #1;
      if (g) resp1_ready = (k == hold); else resp0_ready = (k == hold);
      #2;
      check("resp_valid",     {resp0_valid, resp1_valid}, g ? 2'b01 : 2'b10);
      check("resp_result",    resp_result, exp_res);
      check("resp_zero_err",  {resp_zero, resp_err}, {exp_zero, exp_err});
      check("resp_req_ready", {req0_ready, req1_ready}, 0);
      check("resp_alu_ab",    {alu_a, alu_b}, {a, b});
    end
    @(posedge clk); #1;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    @(posedge clk); #1;
    do_reset();

    // ADD 1+2 on requester 0
    run_txn(1, 0, 4'b0010, 32'h1, 32'h2, 4'b0000, '0, '0, 0);

    // Simultaneous AND/OR: strict alternation starting with requester 0
    do_reset();
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 4'b0000, 32'h10101010, 32'h11001100, 4'b0001, 32'h10101010, 32'h11001100, 0);

    // ADD wrapping to zero on requester 1
    run_txn(0, 1, 4'b0000, '0, '0, 4'b0010, 32'h2, 32'hFFFFFFFE, 0);

    // SUB with a 5-cycle response stall while requester 1 waits
    run_txn(1, 1, 4'b0110, 32'h3, 32'h1, 4'b0001, 32'h5, 32'h6, 5);

    // Illegal op code
    run_txn(1, 0, 4'b0011, 32'hDEAD, 32'hBEEF, 4'b0000, '0, '0, 0);

    // Reset asserted during EXEC of requester 1 SLT
    req0_valid = 0; req1_valid = 1; req1_op = 4'b0111; req1_a = 32'hFFFFFFFF; req1_b = 32'h1;
    #2;
    check("rst_test_accept", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_exec");
    req1_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("rst_no_resp", {resp0_valid, resp1_valid}, 0);
    end
    @(posedge clk); #1;
    run_txn(1, 1, 4'b0010, 32'h7, 32'h8, 4'b0111, 32'h1, 32'h2, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int               sel;
      logic [3:0]       o0, o1;
      logic [WIDTH-1:0] x0, y0, x1, y1;
      sel = $urandom_range(1, 3);
      o0 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : LEGAL_OPS[$urandom_range(0, 5)];
      o1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : LEGAL_OPS[$urandom_range(0, 5)];
      x0 = $urandom; x1 = $urandom;
      y0 = ($urandom_range(0, 3) == 0) ? x0 : 32'($urandom);
      y1 = ($urandom_range(0, 3) == 0) ? x1 : 32'($urandom);
      run_txn(sel[0], sel[1], o0, x0, y0, o1, x1, y1, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
